// File: rtl/mxnbit_set_packer_pkg.sv
// Shared definitions for the mXn-bit sequential blocks: state encodings and sizing helpers.
package mxnbit_set_packer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } packerState_e;

    // Width of a slot index for a given number of sets; never narrower than one bit.
    function automatic int idxWidth(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

endpackage

// File: rtl/mxnbit_set_counter.sv
// Modulo-SETS slot counter with synchronous clear, enable and terminal-count flag.
module mxnbit_set_counter
    import mxnbit_set_packer_pkg::*;
#(
    parameter int SETS  = 2,
    parameter int IDX_W = idxWidth(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [IDX_W-1:0] count_o,
    output logic             terminal_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;

    // Next count: clear wins over enable, and the terminal value wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == LAST_IDX);

endmodule

// File: rtl/mxnbit_set_packer.sv
// Packs a frame of WIDTH-bit sets into one SETS*WIDTH word, flagging short and overlong frames.
module mxnbit_set_packer
    import mxnbit_set_packer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SETS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_set,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [SETS*WIDTH-1:0] out_packed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_short,
    output logic                  out_long
);

    localparam int IDX_W = idxWidth(SETS);
    localparam int BUF_W = SETS * WIDTH;

    if (SETS < 2) begin : g_badSets
        $error("mxnbit_set_packer: SETS must be at least 2");
    end

    packerState_e     state_q;
    packerState_e     state_d;
    logic [BUF_W-1:0] packedBuf_q;
    logic [BUF_W-1:0] packedBuf_d;
    logic             short_q;
    logic             short_d;
    logic             long_q;
    logic             long_d;
    logic             drainPending_q;
    logic             drainPending_d;

    logic             cntClear;
    logic             cntEnable;
    logic [IDX_W-1:0] slotIdx;
    logic             slotIsLast;

    mxnbit_set_counter #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_setCounter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cntClear),
        .enable_i   (cntEnable),
        .count_o    (slotIdx),
        .terminal_o (slotIsLast)
    );

    // Next-state logic: fill slots while collecting, present the word while holding,
    // and swallow the tail of an overlong frame while draining.
    always_comb begin
        state_d        = state_q;
        packedBuf_d    = packedBuf_q;
        short_d        = short_q;
        long_d         = long_q;
        drainPending_d = drainPending_q;
        cntClear       = 1'b0;
        cntEnable      = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    packedBuf_d[int'(slotIdx) * WIDTH +: WIDTH] = in_set;
                    cntEnable = 1'b1;
                    if (in_last || slotIsLast) begin
                        state_d        = HOLD;
                        short_d        = in_last && !slotIsLast;
                        long_d         = !in_last && slotIsLast;
                        drainPending_d = !in_last && slotIsLast;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    packedBuf_d = '0;
                    short_d     = 1'b0;
                    long_d      = 1'b0;
                    cntClear    = 1'b1;
                    state_d     = drainPending_q ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                if (in_valid && in_last) begin
                    state_d        = COLLECT;
                    drainPending_d = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= COLLECT;
            packedBuf_q    <= '0;
            short_q        <= 1'b0;
            long_q         <= 1'b0;
            drainPending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            packedBuf_q    <= packedBuf_d;
            short_q        <= short_d;
            long_q         <= long_d;
            drainPending_q <= drainPending_d;
        end
    end

    assign in_ready   = !rst && (state_q != HOLD);
    assign out_valid  = !rst && (state_q == HOLD);
    assign out_packed = packedBuf_q;
    assign out_short  = short_q;
    assign out_long   = long_q;

endmodule
